// File: rtl/rgb2hsv_pipe_if.sv
// Pixel bus for rgb2hsv_pipe.
//   RGB side : i_rgb_r/g/b (8b each), vs/hs/de
//   HSV side : hsv_h (9b, 0..359), hsv_s (9b, 0..256), hsv_v (8b), hsv_vs/hs/de
// master drives RGB and observes HSV; slave (the converter) does the reverse.
interface rgb2hsv_pipe_if;
  logic [7:0] i_rgb_r, i_rgb_g, i_rgb_b;
  logic       vs, hs, de;
  logic [8:0] hsv_h, hsv_s;
  logic [7:0] hsv_v;
  logic       hsv_vs, hsv_hs, hsv_de;

  modport master (
    output i_rgb_r, i_rgb_g, i_rgb_b, vs, hs, de,
    input  hsv_h, hsv_s, hsv_v, hsv_vs, hsv_hs, hsv_de
  );

  modport slave (
    input  i_rgb_r, i_rgb_g, i_rgb_b, vs, hs, de,
    output hsv_h, hsv_s, hsv_v, hsv_vs, hsv_hs, hsv_de
  );
endinterface

// File: rtl/rgb2hsv_pipe.sv
// Pipelined RGB888 -> HSV converter, one pixel per clock, fixed 5-clock latency.
//   clk      : pixel clock
//   reset_n  : asynchronous active-low reset, clears every pipeline register
//   bus      : rgb2hsv_pipe_if.slave (RGB + syncs in, HSV + delayed syncs out)
// H in degrees 0..359, S = floor(delta*256/max) in 0..256, V = max.
module rgb2hsv_pipe (
  input  logic           clk,
  input  logic           reset_n,
  rgb2hsv_pipe_if.slave  bus
);
  localparam int STAGES = 5;

  // max-channel select codes
  localparam logic [1:0] SEL_R = 2'd0;
  localparam logic [1:0] SEL_G = 2'd1;
  localparam logic [1:0] SEL_B = 2'd2;

  // ---------------- S1: max/min, channel select, direction, d
  logic [7:0] w_max, w_min, w_d;
  logic [1:0] w_sel;
  logic       w_dir;   // set when hue moves forward from the channel base

  always_comb begin
    w_sel = SEL_B;
    w_max = bus.i_rgb_b;
    w_min = (bus.i_rgb_r < bus.i_rgb_g) ? bus.i_rgb_r : bus.i_rgb_g;
    w_dir = (bus.i_rgb_r >= bus.i_rgb_g);
    w_d   = w_dir ? (bus.i_rgb_r - bus.i_rgb_g) : (bus.i_rgb_g - bus.i_rgb_r);
    // ties resolve R over G over B
    if (bus.i_rgb_r >= bus.i_rgb_g && bus.i_rgb_r >= bus.i_rgb_b) begin
      w_sel = SEL_R;
      w_max = bus.i_rgb_r;
      w_min = (bus.i_rgb_g < bus.i_rgb_b) ? bus.i_rgb_g : bus.i_rgb_b;
      w_dir = (bus.i_rgb_g >= bus.i_rgb_b);
      w_d   = w_dir ? (bus.i_rgb_g - bus.i_rgb_b) : (bus.i_rgb_b - bus.i_rgb_g);
    end else if (bus.i_rgb_g >= bus.i_rgb_b) begin
      w_sel = SEL_G;
      w_max = bus.i_rgb_g;
      w_min = (bus.i_rgb_r < bus.i_rgb_b) ? bus.i_rgb_r : bus.i_rgb_b;
      w_dir = (bus.i_rgb_b >= bus.i_rgb_r);
      w_d   = w_dir ? (bus.i_rgb_b - bus.i_rgb_r) : (bus.i_rgb_r - bus.i_rgb_b);
    end
  end

  logic [7:0]  r1_max, r1_min, r1_d;
  logic [1:0]  r1_sel;
  logic        r1_dir;

  // ---------------- S2: delta and both numerators
  logic [7:0]  r2_delta, r2_max;
  logic [13:0] r2_num_h;   // 60*d, at most 15300
  logic [15:0] r2_num_s;   // delta*256
  logic [1:0]  r2_sel;
  logic        r2_dir;

  // ---------------- S3: quotients
  logic [5:0]  r3_q;       // 0..60 since d <= delta
  logic [8:0]  r3_s;       // 0..256 since delta <= max
  logic [7:0]  r3_max;
  logic        r3_dz;      // delta == 0 -> achromatic
  logic [1:0]  r3_sel;
  logic        r3_dir;

  // ---------------- S4: hue base +/- q, wrap, zero-forcing
  logic [8:0]  w_hue_raw, w_hue;

  always_comb begin
    w_hue_raw = '0;
    case (r3_sel)
      SEL_R:   w_hue_raw = r3_dir ? {3'd0, r3_q} : 9'd360 - {3'd0, r3_q};
      SEL_G:   w_hue_raw = r3_dir ? 9'd120 + {3'd0, r3_q} : 9'd120 - {3'd0, r3_q};
      SEL_B:   w_hue_raw = r3_dir ? 9'd240 + {3'd0, r3_q} : 9'd240 - {3'd0, r3_q};
      default: w_hue_raw = '0;
    endcase
    // only the R/backward path with q = 0 can produce 360
    w_hue = (r3_dz || w_hue_raw == 9'd360) ? 9'd0 : w_hue_raw;
  end

  logic [8:0]  r4_h, r4_s;
  logic [7:0]  r4_v;

  // ---------------- S5: output register
  logic [8:0]  r5_h, r5_s;
  logic [7:0]  r5_v;

  // syncs ride a shift register matching the data latency
  logic [STAGES:1][2:0] r_sync_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_max <= '0; r1_min <= '0; r1_d <= '0; r1_sel <= SEL_R; r1_dir <= 1'b0;
      r2_delta <= '0; r2_max <= '0; r2_num_h <= '0; r2_num_s <= '0;
      r2_sel <= SEL_R; r2_dir <= 1'b0;
      r3_q <= '0; r3_s <= '0; r3_max <= '0; r3_dz <= 1'b1;
      r3_sel <= SEL_R; r3_dir <= 1'b0;
      r4_h <= '0; r4_s <= '0; r4_v <= '0;
      r5_h <= '0; r5_s <= '0; r5_v <= '0;
      r_sync_pipe <= '0;
    end else begin
      // S1
      r1_max <= w_max;
      r1_min <= w_min;
      r1_d   <= w_d;
      r1_sel <= w_sel;
      r1_dir <= w_dir;
      // S2
      r2_delta <= r1_max - r1_min;
      r2_max   <= r1_max;
      r2_num_h <= {6'd0, r1_d} * 14'd60;
      r2_num_s <= {r1_max - r1_min, 8'd0};
      r2_sel   <= r1_sel;
      r2_dir   <= r1_dir;
      // S3: divisor-zero cases are forced to 0 rather than left to '/'
      r3_q   <= (r2_delta == 8'd0) ? 6'd0 : 6'(r2_num_h / {6'd0, r2_delta});
      r3_s   <= (r2_max == 8'd0)   ? 9'd0 : 9'(r2_num_s / {8'd0, r2_max});
      r3_max <= r2_max;
      r3_dz  <= (r2_delta == 8'd0);
      r3_sel <= r2_sel;
      r3_dir <= r2_dir;
      // S4
      r4_h <= w_hue;
      r4_s <= r3_s;
      r4_v <= r3_max;
      // S5
      r5_h <= r4_h;
      r5_s <= r4_s;
      r5_v <= r4_v;
      r_sync_pipe <= {r_sync_pipe[STAGES-1:1], {bus.vs, bus.hs, bus.de}};
    end
  end

  assign bus.hsv_h  = r5_h;
  assign bus.hsv_s  = r5_s;
  assign bus.hsv_v  = r5_v;
  assign bus.hsv_vs = r_sync_pipe[STAGES][2];
  assign bus.hsv_hs = r_sync_pipe[STAGES][1];
  assign bus.hsv_de = r_sync_pipe[STAGES][0];

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Bench for rgb2hsv_pipe: table vectors from hand-worked values, model-driven
// sweeps/random pixels, sync alignment and mid-stream reset, all checked
// through a fixed-latency scoreboard queue.
module tb_rgb2hsv_pipe;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  rgb2hsv_pipe_if bus ();
  rgb2hsv_pipe dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [7:0] r, g, b;
    logic [8:0] h, s;
    logic [7:0] v;
  } vec_t;

  typedef struct {
    logic [8:0] h, s;
    logic [7:0] v;
    logic       vs, hs, de;
    bit         chk;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   next_id = 0;

  function automatic exp_t mk(input int h, s, v, input logic vs, hs, de, input bit chk);
    exp_t e;
    e.h = 9'(h); e.s = 9'(s); e.v = 8'(v);
    e.vs = vs; e.hs = hs; e.de = de; e.chk = chk; e.id = -1;
    return e;
  endfunction

  // reference HSV, written straight from the colour-wheel definition
  function automatic exp_t model(input int r, g, b, input logic vs, hs, de);
    int mx, mn, dl, h, s;
    mx = (r > g) ? r : g; mx = (mx > b) ? mx : b;
    mn = (r < g) ? r : g; mn = (mn < b) ? mn : b;
    dl = mx - mn;
    s  = (mx == 0) ? 0 : (dl * 256) / mx;
    if (dl == 0)                 h = 0;
    else if (r >= g && r >= b)   h = (g >= b) ? (60 * (g - b)) / dl : 360 - (60 * (b - g)) / dl;
    else if (g >= b)             h = (b >= r) ? 120 + (60 * (b - r)) / dl : 120 - (60 * (r - b)) / dl;
    else                         h = (r >= g) ? 240 + (60 * (r - g)) / dl : 240 - (60 * (g - r)) / dl;
    if (h == 360) h = 0;
    return mk(h, s, mx, vs, hs, de, 1'b1);
  endfunction

  task automatic compare(input exp_t p);
    bit bad;
    bad = 0;
    n_vec++;
    if (bus.hsv_h !== p.h) begin
      $display("FAIL vec%0d hsv_h got %0d want %0d", p.id, bus.hsv_h, p.h); bad = 1;
    end
    if (bus.hsv_s !== p.s) begin
      $display("FAIL vec%0d hsv_s got %0d want %0d", p.id, bus.hsv_s, p.s); bad = 1;
    end
    if (bus.hsv_v !== p.v) begin
      $display("FAIL vec%0d hsv_v got %0d want %0d", p.id, bus.hsv_v, p.v); bad = 1;
    end
    if ({bus.hsv_vs, bus.hsv_hs, bus.hsv_de} !== {p.vs, p.hs, p.de}) begin
      $display("FAIL vec%0d syncs(vs,hs,de) got %b%b%b want %b%b%b", p.id,
               bus.hsv_vs, bus.hsv_hs, bus.hsv_de, p.vs, p.hs, p.de); bad = 1;
    end
    if (bad) n_err++;
  endtask

  // one pixel clock: retire the result due now, then drive the next pixel
  task automatic cyc(input logic [7:0] r, g, b, input logic vs, hs, de, input exp_t e);
    exp_t p;
    exp_t n;
    @(negedge clk);
    if (exp_q.size() == 5) begin
      p = exp_q.pop_front();
      if (p.chk) compare(p);
    end
    bus.i_rgb_r = r; bus.i_rgb_g = g; bus.i_rgb_b = b;
    bus.vs = vs; bus.hs = hs; bus.de = de;
    n = e;
    n.id = next_id++;
    exp_q.push_back(n);
  endtask

  task automatic px(input int r, g, b, input logic vs, hs, de);
    cyc(8'(r), 8'(g), 8'(b), vs, hs, de, model(r, g, b, vs, hs, de));
  endtask

  // outputs must already be zero; the four slots before the first new pixel are zero too
  task automatic reset_pulse();
    exp_t z;
    #2 reset_n = 1'b0;
    #1;
    z = mk(0, 0, 0, 0, 0, 0, 1'b1);
    z.id = -2;
    compare(z);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      z.id = -3 - i;
      exp_q.push_back(z);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{8'd255, 8'd0,   8'd0,   9'd0,   9'd256, 8'd255};
    tbl[1] = '{8'd0,   8'd255, 8'd0,   9'd120, 9'd256, 8'd255};
    tbl[2] = '{8'd0,   8'd0,   8'd255, 9'd240, 9'd256, 8'd255};
    tbl[3] = '{8'd128, 8'd128, 8'd128, 9'd0,   9'd0,   8'd128};
    tbl[4] = '{8'd0,   8'd0,   8'd0,   9'd0,   9'd0,   8'd0};
    tbl[5] = '{8'd255, 8'd255, 8'd255, 9'd0,   9'd0,   8'd255};
    tbl[6] = '{8'd200, 8'd100, 8'd50,  9'd20,  9'd192, 8'd200};
    tbl[7] = '{8'd255, 8'd0,   8'd128, 9'd330, 9'd256, 8'd255};
    tbl[8] = '{8'd255, 8'd255, 8'd0,   9'd60,  9'd256, 8'd255};
    tbl[9] = '{8'd255, 8'd0,   8'd1,   9'd0,   9'd256, 8'd255};

    bus.i_rgb_r = '0; bus.i_rgb_g = '0; bus.i_rgb_b = '0;
    bus.vs = 1'b0; bus.hs = 1'b0; bus.de = 1'b0;

    // power-on reset
    reset_pulse();

    // hand-worked table, back to back
    foreach (tbl[i])
      cyc(tbl[i].r, tbl[i].g, tbl[i].b, 1'b0, 1'b0, 1'b1,
          mk(tbl[i].h, tbl[i].s, tbl[i].v, 1'b0, 1'b0, 1'b1, 1'b1));

    // sync pattern: vs for two pixels, hs pulse, then 10 pixels of de
    for (int i = 0; i < 14; i++)
      px(i * 17, 255 - i * 9, (i * 41) % 256, (i < 2), (i == 1), (i >= 3 && i < 13));

    // wrap region: R max, G = 0, B swept
    for (int b = 1; b < 256; b++) px(255, 0, b, 1'b0, 1'b0, 1'b1);
    // R swept with G = 0, B = 1
    for (int r = 0; r < 256; r++) px(r, 0, 1, 1'b0, 1'b0, 1'b1);

    // random pixels with random syncs
    for (int i = 0; i < 60; i++)
      px($urandom_range(255), $urandom_range(255), $urandom_range(255),
         1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));

    // reset in the middle of a ramp
    for (int i = 0; i < 7; i++) px(40 + i * 20, 200 - i * 10, i * 30, 1'b0, 1'b0, 1'b1);
    reset_pulse();
    for (int i = 0; i < 8; i++) px(10 + i * 25, 90 + i * 5, 250 - i * 20, 1'b0, (i == 0), 1'b1);

    // drain
    for (int i = 0; i < 6; i++) cyc(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
